// File: rtl/tile_job_dispatcher_if.sv
// Handshake bundle between the tile job dispatcher, the job FIFO read port
// and the PE array. The dispatcher uses the master modport; the surrounding
// environment (FIFO, PEs, host) uses the slave modport.
interface tile_job_dispatcher_if #(
   parameter int DATA_WIDTH = 128,
   parameter int NUM_PE     = 4,
   parameter int CNT_W      = 16
);
   logic                  enable;
   logic                  fifo_empty;
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic [NUM_PE-1:0]     pe_job_valid;
   logic [NUM_PE-1:0]     pe_job_ready;
   logic [DATA_WIDTH-1:0] pe_job_data;
   logic [NUM_PE-1:0]     pe_done;
   logic [NUM_PE-1:0]     busy;
   logic [CNT_W-1:0]      jobs_dispatched;
   logic [CNT_W-1:0]      jobs_completed;
   logic                  idle;

   modport master (
      input  enable, fifo_empty, fifo_rd_data, pe_job_ready, pe_done,
      output fifo_rd_en, pe_job_valid, pe_job_data, busy,
             jobs_dispatched, jobs_completed, idle
   );

   modport slave (
      output enable, fifo_empty, fifo_rd_data, pe_job_ready, pe_done,
      input  fifo_rd_en, pe_job_valid, pe_job_data, busy,
             jobs_dispatched, jobs_completed, idle
   );
endinterface

// File: rtl/tile_job_dispatcher.sv
// Tile job dispatcher: pops one job at a time from the job FIFO and offers it
// to a free processing engine chosen round-robin. Tracks per-PE busy state
// from dispatch/done handshakes and counts dispatched and completed jobs.
module tile_job_dispatcher #(
   parameter int DATA_WIDTH = 128,
   parameter int NUM_PE     = 4,
   parameter int PE_IDX_W   = 2,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   tile_job_dispatcher_if.master bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FETCH    = 2'd1,
      WAIT     = 2'd2,
      DISPATCH = 2'd3
   } state_t;

   state_t                state;
   logic [PE_IDX_W-1:0]   last;
   logic [PE_IDX_W-1:0]   grant;
   logic [DATA_WIDTH-1:0] job;
   logic [NUM_PE-1:0]     busy_q;
   logic [NUM_PE-1:0]     valid_q;
   logic                  rd_en_q;
   logic                  idle_q;
   logic [CNT_W-1:0]      dispatched_q;
   logic [CNT_W-1:0]      completed_q;

   logic [PE_IDX_W-1:0]   grant_free;
   logic                  scan_found;
   int                    scan_idx;
   logic [PE_IDX_W-1:0]   scan_sel;
   logic                  start;
   logic                  handshake;
   logic [NUM_PE-1:0]     done_hit;
   logic [CNT_W-1:0]      done_cnt;
   logic [NUM_PE-1:0]     busy_next;
   logic                  to_idle;

   // First free PE scanning upward from last+1 with wrap-around.
   always_comb begin
      grant_free = '0;
      scan_found = 1'b0;
      scan_idx   = 0;
      scan_sel   = '0;
      for (int k = 1; k <= NUM_PE; k++) begin
         scan_idx = (int'(last) + k) % NUM_PE;
         scan_sel = PE_IDX_W'(scan_idx);
         if (!scan_found && !busy_q[scan_sel]) begin
            grant_free = scan_sel;
            scan_found = 1'b1;
         end
      end
   end

   // Next busy vector: dones clear busy PEs, a dispatch handshake sets the
   // granted PE and wins over a same-cycle done on that PE.
   always_comb begin
      start     = bus.enable && !bus.fifo_empty && !(&busy_q);
      handshake = (state == DISPATCH) && bus.pe_job_ready[grant];
      done_hit  = bus.pe_done & busy_q;
      done_cnt  = CNT_W'($countones(done_hit));
      busy_next = busy_q & ~done_hit;
      if (handshake) begin
         busy_next = busy_next | (NUM_PE'(1) << grant);
      end
      to_idle = ((state == IDLE) && !start) || ((state == DISPATCH) && handshake);
   end

   // Dispatch FSM with registered outputs, busy tracking and job counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         last         <= PE_IDX_W'(NUM_PE - 1);
         grant        <= '0;
         job          <= '0;
         busy_q       <= '0;
         valid_q      <= '0;
         rd_en_q      <= 1'b0;
         idle_q       <= 1'b1;
         dispatched_q <= '0;
         completed_q  <= '0;
      end else begin
         busy_q      <= busy_next;
         completed_q <= completed_q + done_cnt;
         idle_q      <= to_idle && (busy_next == '0);
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= FETCH;
                  rd_en_q <= 1'b1;
               end
            end
            FETCH: begin
               rd_en_q <= 1'b0;
               state   <= WAIT;
            end
            WAIT: begin
               job     <= bus.fifo_rd_data;
               grant   <= grant_free;
               valid_q <= NUM_PE'(1) << grant_free;
               state   <= DISPATCH;
            end
            DISPATCH: begin
               if (handshake) begin
                  valid_q      <= '0;
                  last         <= grant;
                  dispatched_q <= dispatched_q + CNT_W'(1);
                  state        <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.fifo_rd_en      = rd_en_q;
   assign bus.pe_job_valid    = valid_q;
   assign bus.pe_job_data     = job;
   assign bus.busy            = busy_q;
   assign bus.jobs_dispatched = dispatched_q;
   assign bus.jobs_completed  = completed_q;
   assign bus.idle            = idle_q;

endmodule

// File: tb/tb_tile_job_dispatcher.sv
// Testbench for tile_job_dispatcher: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// job-level reference model.
module tb_tile_job_dispatcher;
   localparam int DW = 128;
   localparam int NP = 4;
   localparam int IW = 2;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tile_job_dispatcher_if #(.DATA_WIDTH(DW), .NUM_PE(NP), .CNT_W(CW)) bus ();

   tile_job_dispatcher #(.DATA_WIDTH(DW), .NUM_PE(NP), .PE_IDX_W(IW), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- job FIFO with registered read data ----------------
   logic [DW-1:0] fq[$];
   int            fcount  = 0;
   logic [DW-1:0] pend;
   bit            deliver = 0;
   assign bus.fifo_empty = (fcount == 0);

   task automatic push(input logic [DW-1:0] v);
      fq.push_back(v);
      fcount = fq.size();
   endtask

   always @(negedge clk) begin
      if (deliver) begin
         bus.fifo_rd_data = pend;
         deliver = 0;
      end else begin
         bus.fifo_rd_data = rnd128();
      end
      if (!rst && bus.fifo_rd_en === 1'b1) begin
         pend = (fq.size() > 0) ? fq.pop_front() : rnd128();
         fcount = fq.size();
         deliver = 1;
      end
   end

   // ---------------- reference model ----------------
   // Job lifetime: pop cycle (1), data cycle (2), offer cycles (3), else none (0).
   int            m_phase;
   logic [NP-1:0] m_busy;
   int            m_last, m_g, m_disp, m_comp;
   logic [DW-1:0] m_job;
   logic [NP-1:0] m_nb;
   bit            m_hs;
   bit            m_found;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_busy = '0; m_last = NP - 1; m_g = 0;
         m_job = '0; m_disp = 0; m_comp = 0;
      end else begin
         m_hs = (m_phase == 3) && (bus.pe_job_ready[m_g] === 1'b1);
         m_nb = m_busy;
         for (int i = 0; i < NP; i++) begin
            if (bus.pe_done[i] && m_busy[i]) begin
               m_nb[i] = 1'b0;
               m_comp = (m_comp + 1) % (1 << CW);
            end
         end
         if (m_hs) begin
            m_nb[m_g] = 1'b1;
            m_disp = (m_disp + 1) % (1 << CW);
            m_last = m_g;
         end
         case (m_phase)
            0: if (bus.enable && !bus.fifo_empty && m_busy != '1) m_phase = 1;
            1: m_phase = 2;
            2: begin
               m_job = bus.fifo_rd_data;
               m_found = 0;
               for (int k = 1; k <= NP; k++) begin
                  if (!m_found && !m_busy[(m_last + k) % NP]) begin
                     m_g = (m_last + k) % NP;
                     m_found = 1;
                  end
               end
               m_phase = 3;
            end
            default: if (m_hs) m_phase = 0;
         endcase
         m_busy = m_nb;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("fifo_rd_en", bus.fifo_rd_en, (m_phase == 1));
         chk("pe_job_valid", bus.pe_job_valid, (m_phase == 3) ? (1 << m_g) : 0);
         chk("pe_job_data", bus.pe_job_data, m_job);
         chk("busy", bus.busy, m_busy);
         chk("jobs_dispatched", bus.jobs_dispatched, m_disp);
         chk("jobs_completed", bus.jobs_completed, m_comp);
         chk("idle", bus.idle, (m_phase == 0) && (m_busy == '0));
      end
   end

   // Dispatch log: one line per completed handshake.
   logic [NP-1:0] prev_valid = '0;
   logic [CW-1:0] prev_disp  = '0;
   logic [NP-1:0] grants[$];
   always @(negedge clk) begin
      if (!rst && bus.jobs_dispatched == prev_disp + CW'(1)) begin
         grants.push_back(prev_valid);
         $display("dispatch %0d: pe_valid=%b data=%0h", bus.jobs_dispatched, prev_valid, bus.pe_job_data);
      end
      prev_valid = bus.pe_job_valid;
      prev_disp  = bus.jobs_dispatched;
   end

   // ---------------- helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_fifo();
      fq.delete();
      fcount = 0;
      deliver = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_fifo();
      bus.pe_done = '0;
      grants.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_rd_en(input string name);
      int n = 0;
      while (bus.fifo_rd_en !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (bus.pe_job_valid === '0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk({name, "_timeout"}, 0, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      bus.enable = 1'b0;
      bus.pe_job_ready = '0;
      bus.pe_done = '0;
      rst = 1'b1;
      tick(2);
      chk("rst_valid", bus.pe_job_valid, 0);
      chk("rst_rd_en", bus.fifo_rd_en, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_idle", bus.idle, 1);
      chk("rst_disp", bus.jobs_dispatched, 0);
      rst = 1'b0;
      chk_en = 1;

      // Single job 0xA5.
      bus.enable = 1'b1;
      bus.pe_job_ready = 4'b1111;
      push(128'hA5);
      wait_rd_en("single_pop");
      chk("single_pop", bus.fifo_rd_en, 1);
      @(negedge clk);
      chk("single_wait_valid", bus.pe_job_valid, 0);
      @(negedge clk);
      chk("single_valid", bus.pe_job_valid, 4'b0001);
      chk("single_data", bus.pe_job_data, 128'hA5);
      @(negedge clk);
      chk("single_busy", bus.busy, 4'b0001);
      chk("single_disp", bus.jobs_dispatched, 1);

      // Round-robin across all PEs, then saturation.
      do_reset();
      for (int i = 0; i < 6; i++) push(DW'(i + 1));
      tick(40);
      chk("rr_disp", bus.jobs_dispatched, 4);
      chk("rr_busy", bus.busy, 4'b1111);
      chk("rr_fifo_left", fcount, 2);
      chk("rr_ngrants", grants.size(), 4);
      for (int i = 0; i < 4; i++)
         chk("rr_grant", (grants.size() > i) ? grants[i] : 4'b0000, 4'b0001 << i);
      bus.pe_done = 4'b0010;
      @(negedge clk);
      bus.pe_done = '0;
      tick(10);
      chk("rr_redisp", bus.jobs_dispatched, 5);
      chk("rr_comp", bus.jobs_completed, 1);
      chk("rr_busy2", bus.busy, 4'b1111);
      chk("rr_grant_pe1", (grants.size() > 4) ? grants[4] : 4'b0000, 4'b0010);

      // Backpressure on PE0.
      do_reset();
      bus.pe_job_ready = 4'b1110;
      push(128'h11);
      push(128'h22);
      wait_valid("bp_valid");
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid_hold", bus.pe_job_valid, 4'b0001);
         chk("bp_data_hold", bus.pe_job_data, 128'h11);
         chk("bp_no_pop", bus.fifo_rd_en, 0);
         @(negedge clk);
      end
      bus.pe_job_ready = 4'b1111;
      @(negedge clk);
      chk("bp_busy", bus.busy, 4'b0001);
      chk("bp_disp", bus.jobs_dispatched, 1);
      tick(6);
      chk("bp_busy2", bus.busy, 4'b0011);

      // Done on an idle PE is ignored.
      bus.pe_done = 4'b0100;
      @(negedge clk);
      bus.pe_done = '0;
      chk("idle_done_comp", bus.jobs_completed, 0);
      chk("idle_done_busy", bus.busy, 4'b0011);

      // Simultaneous dones.
      do_reset();
      for (int i = 0; i < 4; i++) push(DW'(i + 8'h40));
      tick(24);
      chk("sim_busy_full", bus.busy, 4'b1111);
      bus.pe_done = 4'b0110;
      @(negedge clk);
      chk("sim_busy_1001", bus.busy, 4'b1001);
      chk("sim_comp2", bus.jobs_completed, 2);
      bus.pe_done = 4'b1001;
      @(negedge clk);
      bus.pe_done = '0;
      chk("sim_busy_0", bus.busy, 4'b0000);
      chk("sim_comp4", bus.jobs_completed, 4);
      chk("sim_idle", bus.idle, 1);
      tick(3);
      chk("empty_no_pop", bus.fifo_rd_en, 0);
      chk("empty_idle", bus.idle, 1);

      // Done in the same cycle as the dispatch handshake to that PE.
      do_reset();
      push(128'h55);
      wait_valid("same_valid");
      bus.pe_done = 4'b0001;
      @(negedge clk);
      bus.pe_done = '0;
      chk("same_busy", bus.busy, 4'b0001);
      chk("same_comp", bus.jobs_completed, 0);
      chk("same_disp", bus.jobs_dispatched, 1);

      // Enable gating.
      do_reset();
      bus.enable = 1'b0;
      push(128'h66);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("en_no_pop", bus.fifo_rd_en, 0);
      end
      chk("en_idle", bus.idle, 1);
      bus.enable = 1'b1;
      wait_rd_en("en_pop");
      @(negedge clk);
      bus.enable = 1'b0;
      tick(3);
      chk("en_drop_disp", bus.jobs_dispatched, 1);
      push(128'h67);
      tick(6);
      chk("en_off_disp", bus.jobs_dispatched, 1);
      chk("en_off_fifo", fcount, 1);

      // Asynchronous reset while a job is being offered.
      do_reset();
      bus.enable = 1'b1;
      push(128'h71);
      push(128'h72);
      tick(12);
      bus.pe_job_ready = '0;
      push(128'h73);
      wait_valid("mid_valid");
      chk("mid_valid_pe2", bus.pe_job_valid, 4'b0100);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", bus.pe_job_valid, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_disp", bus.jobs_dispatched, 0);
      chk("mid_rst_comp", bus.jobs_completed, 0);
      chk("mid_rst_idle", bus.idle, 1);
      clear_fifo();
      grants.delete();
      @(negedge clk);
      rst = 1'b0;
      bus.pe_job_ready = 4'b1111;
      push(128'h88);
      tick(8);
      chk("mid_grant_pe0", (grants.size() > 0) ? grants[0] : 4'b0000, 4'b0001);
      chk("mid_busy", bus.busy, 4'b0001);

      // Randomized traffic.
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         bus.enable = ($urandom_range(0, 9) != 0);
         bus.pe_job_ready = NP'($urandom);
         bus.pe_done = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
         if (fcount < 3 && $urandom_range(0, 2) == 0) push(rnd128());
         if (cyc == 1500) begin
            #3;
            rst = 1'b1;
            #1;
            chk("rand_rst_busy", bus.busy, 0);
            clear_fifo();
            @(negedge clk);
            rst = 1'b0;
         end
      end
      bus.pe_done = '0;
      tick(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/tile_job_dispatcher.md
# tile_job_dispatcher

Pops tile jobs from the job FIFO and hands each to one of NUM_PE processing engines, choosing round-robin among engines with no job in flight. Sits between the job FIFO read port and the PE array; tracks per-PE busy state from dispatch and done handshakes, and keeps dispatched/completed job counters for the host.

## Interface
- DATA_WIDTH, 128, job descriptor width; equals the job FIFO data width
- NUM_PE, 4, number of processing engines, 2..16
- PE_IDX_W, 2, log2(NUM_PE)
- CNT_W, 16, width of the job counters
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  allows new FIFO fetches
- fifo_empty  in  1  job FIFO empty flag
- fifo_rd_en  out  1  job FIFO pop; rd_data is registered, valid the cycle after the pop
- fifo_rd_data  in  DATA_WIDTH  job FIFO read data
- pe_job_valid  out  NUM_PE  one-hot job offer to PE i
- pe_job_ready  in  NUM_PE  PE i accepts the job
- pe_job_data  out  DATA_WIDTH  job descriptor, shared by all PEs
- pe_done  in  NUM_PE  single-cycle pulse: PE i finished its job
- busy  out  NUM_PE  PE i has a job in flight
- jobs_dispatched  out  CNT_W  count of completed dispatch handshakes
- jobs_completed  out  CNT_W  count of accepted done pulses
- idle  out  1  FSM in IDLE and busy == 0

## Operation
- Reset values: fifo_rd_en 0, pe_job_valid 0, pe_job_data 0, busy 0, both counters 0, idle 1, FSM IDLE, grant pointer last = NUM_PE-1, so the first grant goes to PE0.
- FSM states: IDLE, FETCH, WAIT, DISPATCH.
- IDLE -> FETCH when enable && !fifo_empty && (busy != all ones). Otherwise stay in IDLE.
- FETCH: fifo_rd_en = 1 for exactly this one cycle (Moore output). Next state is WAIT.
- WAIT: latch fifo_rd_data into the job register, which drives pe_job_data.
  - Register the grant g: the first PE with busy[g] == 0, scanning from last+1 upward and wrapping modulo NUM_PE.
  - Next state is DISPATCH.
- DISPATCH: pe_job_valid[g] = 1. All other bits are 0.
  - pe_job_data and g stay stable until the handshake.
  - The handshake is pe_job_valid[g] && pe_job_ready[g] in the same cycle. On handshake: busy[g] is set, last becomes g, jobs_dispatched increments, next state is IDLE.
  - With no handshake, DISPATCH holds indefinitely.
  - pe_job_ready on non-granted PEs is ignored.
- The free PE chosen in WAIT remains free through DISPATCH, because only this block sets busy bits.
- Done handling runs in every state. For each i with pe_done[i] && busy[i]: clear busy[i] and add 1 to jobs_completed; multiple simultaneous dones add their popcount.
- A done pulse on a PE with busy 0 is ignored: no busy change, no count.
- If a done on PE g arrives in the same cycle as the dispatch handshake to g, busy[g] ends set, because the new job takes precedence. jobs_completed still increments only if busy[g] was 1 before that edge.
- Deasserting enable blocks only the IDLE -> FETCH transition. A job already in FETCH, WAIT or DISPATCH runs to its handshake.
- Counters wrap modulo 2^CNT_W.
- Reset asserted mid-operation returns all state to reset values immediately. A job already popped in WAIT or DISPATCH is discarded; recovery is the host's responsibility.

## Timing
- Pop at cycle T (FETCH). Job register loaded at the end of T+1 (WAIT). pe_job_valid asserts at T+2.
- With ready held high, the handshake lands at T+2, the FSM is in IDLE at T+3, and the next pop is earliest at T+4. Peak throughput is 1 job per 4 cycles.
- busy, counters and idle update on the clock edge ending the handshake or done cycle.
- idle is registered-state decode: it is 1 only when the FSM is in IDLE and busy == 0.

## Test plan
- Reset and single job: reset, enable=1, FIFO holds job 0xA5, all PEs ready.
  - fifo_rd_en pulses once at T; pe_job_valid=0001 with data 0xA5 at T+2.
  - Then busy=0001 and jobs_dispatched=1.
- Round-robin: 6 jobs, all PEs ready, no dones.
  - Grants go to PE0, 1, 2, 3.
  - After that, busy=1111, no further FIFO pops, and jobs_dispatched=4.
  - A done pulse on PE1 leads to the next grant to PE1, then busy=1111 again.
- Backpressure: pe_job_ready[0]=0 for 10 cycles.
  - pe_job_valid=0001 and pe_job_data stay stable and no pop occurs.
  - The handshake happens in the cycle ready rises.
- Done corner cases:
  - A done on idle PE2 leaves jobs_completed unchanged.
  - Simultaneous dones on PE0 and PE3, both busy, give jobs_completed +2 and busy 1001 -> 0000.
  - A done on PE0 in the same cycle as its dispatch handshake leaves busy[0]=1.
- Enable and empty: fifo_empty=1 or enable=0 gives no fifo_rd_en and idle=1 once all dones arrive. Dropping enable during WAIT still completes that dispatch.
- Reset mid-dispatch: assert rst while in DISPATCH.
  - pe_job_valid, busy and counters go to 0 without waiting for a clock edge.
  - After release, the next grant goes to PE0.
